barrett_stream_driver: RTL and testbench

- Initiator side of the Barrett reducer start/valid interface (barrett_parallel_top).
- Accepts a valid/ready stream of operands x, issues one single-cycle start per operand to the reducer core, and waits for the core's valid.
- Results are buffered in an output FIFO and emitted on a valid/ready stream, in input order.
- Zero and out-of-range operands are handled locally; a stalled core is caught by a timeout.

---
 rtl/barrett_stream_driver.sv | 171 +++++++++++++++++
 tb/tb_barrett_stream_driver.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrett_stream_driver.sv
// Stream front end for the Barrett reducer core: issues one start per operand, waits
// for the core result (or a timeout) and returns results in order through a small FIFO.
module barrett_stream_driver #(
    parameter int DATA_LENGTH    = 64,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_LENGTH-1:0] in_x_i,
    input  logic [DATA_LENGTH-1:0] m_i,
    input  logic [DATA_LENGTH-1:0] mu_i,
    input  logic [DATA_LENGTH-1:0] m_bl_i,
    output logic                   core_start_o,
    output logic [DATA_LENGTH-1:0] core_x_o,
    output logic [DATA_LENGTH-1:0] core_m_o,
    output logic [DATA_LENGTH-1:0] core_mu_o,
    output logic [DATA_LENGTH-1:0] core_m_bl_o,
    input  logic [DATA_LENGTH-1:0] core_result_i,
    input  logic                   core_valid_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_LENGTH-1:0] out_r_o,
    output logic                   out_err_o,
    output logic                   busy_o,
    output logic [31:0]            count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]                              state_q, state_d;
    logic [TW-1:0]                           tmo_q, tmo_d;
    logic                                    start_q, start_d;
    logic [DATA_LENGTH-1:0]                  x_q, x_d, m_q, m_d, mu_q, mu_d, m_bl_q, m_bl_d;
    logic [FIFO_DEPTH-1:0][DATA_LENGTH-1:0]  mem_q, mem_d;
    logic [FIFO_DEPTH-1:0]                   err_q, err_d;
    logic [AW:0]                             wr_q, wr_d, rd_q, rd_d;
    logic [31:0]                             count_q, count_d;

    logic                   full, empty, accept, pop, push, push_err, out_of_range;
    logic [DATA_LENGTH-1:0] push_r;
    logic [DATA_LENGTH:0]   shamt;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty  = (wr_q == rd_q);
    assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign accept = in_valid_i && in_ready_o;
    assign pop    = !empty && out_ready_i;

    // Operands at or above 2^(2*m_bl) are outside the range the Barrett core handles.
    assign shamt        = {m_bl_i, 1'b0};
    assign out_of_range = ((in_x_i >> shamt) != '0);

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        start_d  = 1'b0;
        x_d      = x_q;
        m_d      = m_q;
        mu_d     = mu_q;
        m_bl_d   = m_bl_q;
        push     = 1'b0;
        push_err = 1'b0;
        push_r   = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_x_i == '0) begin
                        push = 1'b1;
                    end else if (out_of_range) begin
                        push     = 1'b1;
                        push_err = 1'b1;
                    end else begin
                        x_d     = in_x_i;
                        m_d     = m_i;
                        mu_d    = mu_i;
                        m_bl_d  = m_bl_i;
                        start_d = 1'b1;
                        state_d = START;
                    end
                end
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (core_valid_i) begin
                    push    = 1'b1;
                    push_r  = core_result_i;
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    push     = 1'b1;
                    push_err = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A push never overflows: the FIFO slot was reserved when the operand was accepted.
    always_comb begin
        mem_d   = mem_q;
        err_d   = err_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = push_r;
            err_d[wr_q[AW-1:0]] = push_err;
            wr_d                = wr_q + 1'b1;
            count_d             = count_q + 32'd1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            start_q <= 1'b0;
            x_q     <= '0;
            m_q     <= '0;
            mu_q    <= '0;
            m_bl_q  <= '0;
            mem_q   <= '0;
            err_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            start_q <= start_d;
            x_q     <= x_d;
            m_q     <= m_d;
            mu_q    <= mu_d;
            m_bl_q  <= m_bl_d;
            mem_q   <= mem_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign in_ready_o   = (state_q == IDLE) && !full;
    assign core_start_o = start_q;
    assign core_x_o     = x_q;
    assign core_m_o     = m_q;
    assign core_mu_o    = mu_q;
    assign core_m_bl_o  = m_bl_q;
    assign out_valid_o  = !empty;
    assign out_r_o      = mem_q[rd_q[AW-1:0]];
    assign out_err_o    = err_q[rd_q[AW-1:0]];
    assign busy_o       = (state_q != IDLE);
    assign count_o      = count_q;

endmodule

// File: tb/tb_barrett_stream_driver.sv
// Self-checking bench for barrett_stream_driver: a behavioural reducer core model plus
// an in-order queue of expected results built from the operand classification rules.
module tb_barrett_stream_driver;
    localparam int DL = 64;
    localparam int TO = 64;
    localparam logic [DL-1:0] MOD = 64'd8380417;
    localparam logic [DL-1:0] MU  = 64'd8396807;
    localparam logic [DL-1:0] MBL = 64'd23;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i, in_valid_i, in_ready_o, core_start_o, core_valid_i;
    logic          out_valid_o, out_ready_i, out_err_o, busy_o;
    logic [DL-1:0] in_x_i, m_i, mu_i, m_bl_i, core_x_o, core_m_o, core_mu_o, core_m_bl_o;
    logic [DL-1:0] core_result_i, out_r_o;
    logic [31:0]   count_o;

    barrett_stream_driver #(.DATA_LENGTH(DL), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_x_i(in_x_i),
        .m_i(m_i), .mu_i(mu_i), .m_bl_i(m_bl_i),
        .core_start_o(core_start_o), .core_x_o(core_x_o), .core_m_o(core_m_o),
        .core_mu_o(core_mu_o), .core_m_bl_o(core_m_bl_o),
        .core_result_i(core_result_i), .core_valid_i(core_valid_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_r_o(out_r_o),
        .out_err_o(out_err_o), .busy_o(busy_o), .count_o(count_o)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [DL:0] exp_q[$];
    int pushes = 0, starts = 0, core_cd = 0, stray_cd = 0, core_latency = 3;
    bit core_respond = 1'b1, op_respond = 1'b1, rand_ready = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected FIFO entry {err, r} for an accepted operand.
    function automatic logic [DL:0] expectedEntry(input logic [DL-1:0] x, input logic [DL-1:0] m,
                                                   input logic [DL-1:0] mbl, input bit responds);
        int twice;
        twice = 2 * int'(mbl);
        if (x == 0) return {1'b0, 64'd0};
        if (twice < DL && x >= (64'd1 << twice)) return {1'b1, 64'd0};
        if (!responds) return {1'b1, 64'd0};
        return {1'b0, x % m};
    endfunction

    function automatic logic [DL-1:0] randInRange();
        logic [DL-1:0] r;
        r = {$urandom, $urandom};
        return r & 64'h0000_3FFF_FFFF_FFFF;
    endfunction

    function automatic logic [DL-1:0] randOutOfRange();
        logic [DL-1:0] r;
        r = {$urandom, $urandom};
        return r | (64'd1 << (46 + $urandom_range(0, 17)));
    endfunction

    // One clock cycle: observe the current cycle, then drive the reducer model for the next.
    task automatic tick();
        logic        nxt_valid, nxt_stray;
        logic [DL:0] head;
        if (rst_i) begin
            exp_q.delete();
            pushes  = 0;
            core_cd = 0;
        end else begin
            if (in_valid_i && in_ready_o) begin
                op_respond = core_respond;
                exp_q.push_back(expectedEntry(in_x_i, m_i, m_bl_i, core_respond));
                pushes++;
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    checkOutput("pop_without_expected_entry", 64'(out_valid_o), 64'd0);
                end else begin
                    head = exp_q.pop_front();
                    checkOutput("out_r", out_r_o, head[DL-1:0]);
                    checkOutput("out_err", 64'(out_err_o), 64'(head[DL]));
                end
            end
        end
        if (core_start_o) starts++;
        nxt_valid = 1'b0;
        nxt_stray = 1'b0;
        if (!rst_i && core_start_o && op_respond) begin
            core_cd = core_latency;
        end else if (core_cd > 0) begin
            core_cd--;
            nxt_valid = (core_cd == 0);
        end
        if (stray_cd > 0) begin
            stray_cd--;
            nxt_stray = (stray_cd == 0);
        end
        @(posedge clk);
        @(negedge clk);
        core_valid_i  = nxt_valid | nxt_stray;
        core_result_i = nxt_valid ? (core_x_o % core_m_o) : {$urandom, $urandom};
        if (rand_ready) out_ready_i = ($urandom_range(0, 1) == 1);
    endtask

    // Present one operand until accepted; returns observing the cycle after acceptance.
    task automatic applyStimulus(input logic [DL-1:0] x, input int budget);
        int   n;
        logic acc;
        n = 0;
        in_valid_i = 1'b1;
        in_x_i     = x;
        do begin
            acc = in_ready_o;
            tick();
            n++;
        end while (!acc && n < budget);
        in_valid_i = 1'b0;
        in_x_i     = {$urandom, $urandom};
        if (!acc) checkOutput("accept_within_budget", 64'(acc), 64'd1);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy_o || out_valid_o) && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, {62'd0, busy_o, out_valid_o}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, s0, p0;
        logic acc;
        logic [DL-1:0] x;
        logic [DL-1:0] bp_x[5];

        rst_i = 1'b1; in_valid_i = 1'b0; in_x_i = '0;
        m_i = MOD; mu_i = MU; m_bl_i = MBL;
        core_valid_i = 1'b0; core_result_i = '0; out_ready_i = 1'b1;
        @(negedge clk);

        $display("[TB] reset state");
        tick(); tick();
        checkOutput("reset_busy", 64'(busy_o), 64'd0);
        checkOutput("reset_out_valid", 64'(out_valid_o), 64'd0);
        checkOutput("reset_count", 64'(count_o), 64'd0);
        checkOutput("reset_core_start", 64'(core_start_o), 64'd0);
        checkOutput("reset_core_x", core_x_o, 64'd0);
        checkOutput("reset_out_err", 64'(out_err_o), 64'd0);
        rst_i = 1'b0;
        tick();

        $display("[TB] normal reduction");
        s0 = starts;
        applyStimulus(64'h12345678, 10);
        checkOutput("normal_core_start", 64'(core_start_o), 64'd1);
        checkOutput("normal_core_x", core_x_o, 64'h12345678);
        checkOutput("normal_core_m", core_m_o, MOD);
        checkOutput("normal_core_mu", core_mu_o, MU);
        checkOutput("normal_core_m_bl", core_m_bl_o, MBL);
        checkOutput("normal_busy", 64'(busy_o), 64'd1);
        n = 0;
        while (!out_valid_o && n < 20) begin tick(); n++; end
        checkOutput("normal_latency", 64'(n), 64'd5);
        checkOutput("normal_out_r", out_r_o, 64'd3724884);
        checkOutput("normal_out_err", 64'(out_err_o), 64'd0);
        checkOutput("normal_count", 64'(count_o), 64'd1);
        checkOutput("normal_start_pulses", 64'(starts - s0), 64'd1);
        drain("normal_drain", 10);

        $display("[TB] zero bypass");
        s0 = starts;
        applyStimulus(64'd0, 10);
        checkOutput("zero_out_valid", 64'(out_valid_o), 64'd1);
        checkOutput("zero_out_r", out_r_o, 64'd0);
        checkOutput("zero_out_err", 64'(out_err_o), 64'd0);
        checkOutput("zero_busy", 64'(busy_o), 64'd0);
        drain("zero_drain", 10);
        checkOutput("zero_no_start", 64'(starts - s0), 64'd0);

        $display("[TB] range error and range edge");
        s0 = starts;
        applyStimulus(64'h0000_4000_0000_0000, 10);
        checkOutput("range_out_valid", 64'(out_valid_o), 64'd1);
        checkOutput("range_out_r", out_r_o, 64'd0);
        checkOutput("range_out_err", 64'(out_err_o), 64'd1);
        drain("range_drain", 10);
        checkOutput("range_no_start", 64'(starts - s0), 64'd0);
        applyStimulus(64'h0000_3FFF_FFFF_FFFF, 10);
        checkOutput("range_edge_start", 64'(core_start_o), 64'd1);
        drain("range_edge_drain", 40);
        checkOutput("range_count", 64'(count_o), 64'd4);

        $display("[TB] timeout");
        core_respond = 1'b0;
        applyStimulus(64'h1234, 10);
        n = 0;
        while (!out_valid_o && n < 200) begin tick(); n++; end
        checkOutput("timeout_latency", 64'(n), 64'(TO + 1));
        checkOutput("timeout_out_r", out_r_o, 64'd0);
        checkOutput("timeout_out_err", 64'(out_err_o), 64'd1);
        checkOutput("timeout_busy", 64'(busy_o), 64'd0);
        core_respond = 1'b1;
        stray_cd = 10;
        repeat (15) tick();
        checkOutput("timeout_stray_count", 64'(count_o), 64'(pushes));
        checkOutput("timeout_stray_out_valid", 64'(out_valid_o), 64'd0);

        $display("[TB] back-pressure");
        p0 = pushes;
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) bp_x[i] = randInRange();
        for (int i = 0; i < 4; i++) applyStimulus(bp_x[i], 40);
        in_valid_i = 1'b1;
        in_x_i     = bp_x[4];
        repeat (30) tick();
        checkOutput("bp_in_ready_blocked", 64'(in_ready_o), 64'd0);
        checkOutput("bp_out_valid", 64'(out_valid_o), 64'd1);
        checkOutput("bp_head_first", out_r_o, bp_x[0] % MOD);
        checkOutput("bp_count_full", 64'(count_o), 64'(p0 + 4));
        out_ready_i = 1'b1;
        n = 0;
        do begin
            acc = in_ready_o;
            tick();
            n++;
        end while (!acc && n < 20);
        in_valid_i = 1'b0;
        checkOutput("bp_fifth_accepted", 64'(acc), 64'd1);
        checkOutput("bp_fifth_wait", 64'(n), 64'd2);
        drain("bp_drain", 60);
        checkOutput("bp_count_final", 64'(count_o), 64'(p0 + 5));

        $display("[TB] reset mid-operation");
        core_latency = 20;
        applyStimulus(randInRange(), 10);
        repeat (3) tick();
        checkOutput("rst_mid_busy_before", 64'(busy_o), 64'd1);
        rst_i    = 1'b1;
        stray_cd = 4;
        tick();
        rst_i = 1'b0;
        checkOutput("rst_mid_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_mid_out_valid", 64'(out_valid_o), 64'd0);
        checkOutput("rst_mid_count", 64'(count_o), 64'd0);
        repeat (8) tick();
        checkOutput("rst_mid_stray_count", 64'(count_o), 64'd0);
        checkOutput("rst_mid_stray_out_valid", 64'(out_valid_o), 64'd0);
        core_latency = 2;
        x = randInRange();
        applyStimulus(x, 10);
        drain("rst_recover_drain", 40);
        checkOutput("rst_recover_count", 64'(count_o), 64'd1);

        $display("[TB] randomized traffic");
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       x = 64'd0;
                1:       x = randOutOfRange();
                2:       x = 64'h0000_3FFF_FFFF_FFFF;
                3:       x = 64'h0000_4000_0000_0000;
                default: x = randInRange();
            endcase
            core_latency = $urandom_range(1, 8);
            core_respond = ($urandom_range(0, 15) != 0);
            applyStimulus(x, 400);
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_ready   = 1'b0;
        out_ready_i  = 1'b1;
        core_respond = 1'b1;
        drain("random_drain", 400);
        checkOutput("random_count", 64'(count_o), 64'(pushes));
        checkOutput("model_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
